// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V core: FSM states, opcodes,
// ALU mux selects and the control-word payload driven by the sequencer.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_ERROR  = 4'd10,
    S_BRANCH = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_REG   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Full set of datapath controls produced each cycle by the sequencer.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // States that own the memory port and may stall on mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/riscv_wait_timer.sv
// Counts consecutive stalled cycles of a memory state; expire flags the
// last permitted stall cycle so the sequencer can divert to ERROR.
module riscv_wait_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = (count == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle control sequencer: walks fetch/decode/execute/memory/writeback
// states, driving the shared ALU and unified memory port selects.
module riscv_multicycle_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state_o
);

  import riscv_pkg::*;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl;
  logic   timer_clear;
  logic   timer_enable;
  logic   timer_expire;

  riscv_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Stall count is per visit: any transition restarts it.
  assign timer_enable = is_wait_state(state) && !mem_ready;
  assign timer_clear  = (state_next != state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ctrl       = CTRL_IDLE;
    unique case (state)
      S_RESET: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = ALU_SRC_A_PC;
        ctrl.alu_src_b = ALU_SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        // IR captures the word and PC takes PC+4 in the same ready cycle.
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_next    = S_DECODE;
        end else if (timer_expire) begin
          state_next = S_ERROR;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_a = ALU_SRC_A_OLDPC;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_BRANCH:         state_next = S_BRANCH;
          default: begin
            ctrl.illegal_op = 1'b1;
            ctrl.instr_done = 1'b1;
            state_next      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_next     = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timer_expire) begin
          state_next = S_ERROR;
        end
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
        state_next      = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_next      = S_FETCH;
        end else if (timer_expire) begin
          state_next = S_ERROR;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = ALU_SRC_A_REG;
        ctrl.alu_src_b = ALU_SRC_B_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_next     = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
        state_next      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = ALU_SRC_A_REG;
        ctrl.alu_src_b  = ALU_SRC_B_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = 1'b1;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
        state_next      = S_FETCH;
      end
      S_ERROR: begin
        // Terminal until reset; inputs are deliberately ignored.
        ctrl.mem_timeout = 1'b1;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  assign pc_write    = ctrl.pc_write;
  assign ir_write    = ctrl.ir_write;
  assign iord        = ctrl.iord;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign reg_write   = ctrl.reg_write;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_op      = ctrl.alu_op;
  assign pc_src      = ctrl.pc_src;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign mem_timeout = ctrl.mem_timeout;
  assign state_o     = state;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: each cycle pushes the expected
// control word for the driven inputs and compares it against the DUT outputs.
module tb_riscv_multicycle_ctrl;

  localparam int unsigned MAX_WAIT = 4;

  localparam logic [3:0] ST_RST = 4'd0;
  localparam logic [3:0] ST_FET = 4'd1;
  localparam logic [3:0] ST_DEC = 4'd2;
  localparam logic [3:0] ST_MAD = 4'd3;
  localparam logic [3:0] ST_MRD = 4'd4;
  localparam logic [3:0] ST_MWB = 4'd5;
  localparam logic [3:0] ST_MWR = 4'd6;
  localparam logic [3:0] ST_EXR = 4'd7;
  localparam logic [3:0] ST_EXI = 4'd8;
  localparam logic [3:0] ST_AWB = 4'd9;
  localparam logic [3:0] ST_ERR = 4'd10;
  localparam logic [3:0] ST_BR  = 4'd11;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, alu_op;
  logic       pc_src, instr_done, illegal_op, mem_timeout;
  logic [3:0] state_o;

  int          checks = 0;
  int          failures = 0;
  logic [20:0] exp_q[$];
  string       tag_q[$];

  riscv_multicycle_ctrl #(
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .pc_src      (pc_src),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%06h expected=%06h", tag, got, exp);
    end
  endtask

  // Expected control word for a state, written from the state table.
  function automatic logic [20:0] expect_word(input logic [3:0] st, input logic [6:0] op,
                                              input logic rdy, input logic z);
    logic pcw, irw, ios, mrd, mwr, rw, m2r, psrc, done, ill, tmo;
    logic [1:0] sa, sb, aop;
    pcw = 0; irw = 0; ios = 0; mrd = 0; mwr = 0; rw = 0; m2r = 0;
    psrc = 0; done = 0; ill = 0; tmo = 0; sa = 2'b00; sb = 2'b00; aop = 2'b00;
    case (st)
      ST_FET: begin mrd = 1; sb = 2'b10; irw = rdy; pcw = rdy; end
      ST_DEC: begin
        sa = 2'b01; sb = 2'b01;
        if (!(op == OPC_LW || op == OPC_SW || op == OPC_R || op == OPC_I || op == OPC_BEQ)) begin
          ill = 1; done = 1;
        end
      end
      ST_MAD: begin sa = 2'b10; sb = 2'b01; end
      ST_MRD: begin mrd = 1; ios = 1; end
      ST_MWB: begin rw = 1; m2r = 1; done = 1; end
      ST_MWR: begin mwr = 1; ios = 1; done = rdy; end
      ST_EXR: begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
      ST_EXI: begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      ST_AWB: begin rw = 1; done = 1; end
      ST_BR:  begin sa = 2'b10; aop = 2'b01; psrc = 1; pcw = z; done = 1; end
      ST_ERR: tmo = 1;
      default: ;
    endcase
    return {pcw, irw, ios, mrd, mwr, rw, m2r, sa, sb, aop, psrc, done, ill, tmo, st};
  endfunction

  function automatic logic [20:0] observed_word();
    return {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
            alu_src_a, alu_src_b, alu_op, pc_src, instr_done, illegal_op, mem_timeout, state_o};
  endfunction

  // One clock: drive inputs after the edge, queue expectation, compare mid-cycle.
  task automatic step(input string tag, input logic r, input logic [6:0] op,
                      input logic z, input logic rdy, input logic [3:0] st);
    @(posedge clk);
    #2;
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    exp_q.push_back(expect_word(st, op, rdy, z));
    tag_q.push_back(tag);
    #3;
    check_eq(tag_q.pop_front(), observed_word(), exp_q.pop_front());
  endtask

  initial begin
    step("reset_hold", 1, OPC_R, 0, 1, ST_RST);
    step("reset_rel",  0, OPC_R, 0, 1, ST_RST);

    // R-type, zero-wait memory: done on 4th cycle from fetch
    step("r_fetch", 0, OPC_R, 0, 1, ST_FET);
    step("r_dec",   0, OPC_R, 0, 1, ST_DEC);
    step("r_exec",  0, OPC_R, 0, 1, ST_EXR);
    step("r_wb",    0, OPC_R, 0, 1, ST_AWB);

    // I-type with mem_ready low outside memory states
    step("i_fetch", 0, OPC_I, 0, 1, ST_FET);
    step("i_dec",   0, OPC_I, 0, 0, ST_DEC);
    step("i_exec",  0, OPC_I, 0, 0, ST_EXI);
    step("i_wb",    0, OPC_I, 0, 0, ST_AWB);

    // LW: fetch ready on the last allowed stall, then 3 stalls in MEMRD
    step("lw_fetch_w0", 0, OPC_LW, 0, 0, ST_FET);
    step("lw_fetch_w1", 0, OPC_LW, 0, 0, ST_FET);
    step("lw_fetch_w2", 0, OPC_LW, 0, 0, ST_FET);
    step("lw_fetch_rdy", 0, OPC_LW, 0, 1, ST_FET);
    step("lw_dec",      0, OPC_LW, 0, 1, ST_DEC);
    step("lw_madr",     0, OPC_LW, 0, 1, ST_MAD);
    step("lw_mrd_w0",   0, OPC_LW, 0, 0, ST_MRD);
    step("lw_mrd_w1",   0, OPC_LW, 0, 0, ST_MRD);
    step("lw_mrd_w2",   0, OPC_LW, 0, 0, ST_MRD);
    step("lw_mrd_rdy",  0, OPC_LW, 0, 1, ST_MRD);
    step("lw_wb",       0, OPC_LW, 0, 1, ST_MWB);

    // SW with one stall in MEMWR
    step("sw_fetch",   0, OPC_SW, 0, 1, ST_FET);
    step("sw_dec",     0, OPC_SW, 0, 1, ST_DEC);
    step("sw_madr",    0, OPC_SW, 0, 1, ST_MAD);
    step("sw_mwr_w0",  0, OPC_SW, 0, 0, ST_MWR);
    step("sw_mwr_rdy", 0, OPC_SW, 0, 1, ST_MWR);

    // BEQ taken and not taken
    step("beq1_fetch", 0, OPC_BEQ, 1, 1, ST_FET);
    step("beq1_dec",   0, OPC_BEQ, 1, 1, ST_DEC);
    step("beq1_br",    0, OPC_BEQ, 1, 1, ST_BR);
    step("beq0_fetch", 0, OPC_BEQ, 0, 1, ST_FET);
    step("beq0_dec",   0, OPC_BEQ, 0, 1, ST_DEC);
    step("beq0_br",    0, OPC_BEQ, 0, 1, ST_BR);

    // Illegal opcode then straight back to fetch
    step("bad_fetch", 0, OPC_BAD, 1, 1, ST_FET);
    step("bad_dec",   0, OPC_BAD, 1, 1, ST_DEC);

    // Reset asserted while a store waits in MEMWR
    step("rs_fetch",   0, OPC_SW, 0, 1, ST_FET);
    step("rs_dec",     0, OPC_SW, 0, 1, ST_DEC);
    step("rs_madr",    0, OPC_SW, 0, 1, ST_MAD);
    step("rs_mwr_w0",  0, OPC_SW, 0, 0, ST_MWR);
    step("rs_assert",  1, OPC_SW, 0, 0, ST_RST);
    step("rs_release", 0, OPC_SW, 0, 0, ST_RST);

    // Fetch starved for MAX_WAIT cycles -> sticky ERROR
    step("to_fetch_w0", 0, OPC_R, 0, 0, ST_FET);
    step("to_fetch_w1", 0, OPC_R, 0, 0, ST_FET);
    step("to_fetch_w2", 0, OPC_R, 0, 0, ST_FET);
    step("to_fetch_w3", 0, OPC_R, 0, 0, ST_FET);
    step("to_err0",     0, OPC_R, 0, 1, ST_ERR);
    step("to_err1",     0, OPC_BEQ, 1, 1, ST_ERR);
    step("to_err2",     0, OPC_LW, 0, 0, ST_ERR);

    // Reset clears ERROR
    step("err_rst",     1, OPC_R, 0, 1, ST_RST);
    step("err_rel",     0, OPC_R, 0, 1, ST_RST);
    step("err_fetch",   0, OPC_R, 0, 1, ST_FET);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
